multicycle_ctrl: RTL and testbench

//  Parametrised successor to the multicycle decode/control unit. Holds the main FSM,
//  ALU decoder, PC-select logic and instruction decoder of the multicycle ARM core.

---
 rtl/multicycle_ctrl_pkg.sv | 70 +++++++
 rtl/multicycle_ctrl_if.sv | 45 ++++
 rtl/multicycle_ctrl_alu_dec.sv | 56 +++++
 rtl/multicycle_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// multicycle_ctrl_pkg
//   Shared definitions for the multicycle control unit: FSM state encoding,
//   datapath mux-select codes, ALU operation codes, ALU command (Funct[4:1])
//   codes and a small register-source helper.
//   No ports; imported by the interface users, the ALU decoder and the top.
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_MULEXEC,
    S_MULWB
  } state_t;

  // Instruction class, Instr[27:26]
  localparam logic [1:0] OP_DP     = 2'b00;
  localparam logic [1:0] OP_MEM    = 2'b01;
  localparam logic [1:0] OP_BRANCH = 2'b10;
  localparam logic [1:0] OP_UNDEF  = 2'b11;

  // Address source
  localparam logic ADR_PC  = 1'b0;
  localparam logic ADR_ALU = 1'b1;

  // Result source
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_READDATA  = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic [1:0] RES_MUL       = 2'b11;

  // ALU operand A / B sources
  localparam logic [1:0] SRCA_RD1  = 2'b00;
  localparam logic [1:0] SRCA_PC   = 2'b01;
  localparam logic [1:0] SRCA_ZERO = 2'b10;
  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // ALU operation codes (low three bits of ALUControl)
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_EOR = 3'b100;
  localparam logic [2:0] ALU_MOV = 3'b101;

  // Data-processing commands, Funct[4:1]
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_TST = 4'b1000;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  // Register-file read-port selects follow directly from the instruction class
  function automatic logic [1:0] regSrcOf(input logic [1:0] op);
    return {op == OP_MEM, op == OP_BRANCH};
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if
//   Bundles the instruction fields entering the control unit and every
//   select/enable it returns to the datapath.
//   master (datapath side): drives Op, Funct, Rd, IsMul, MemReady;
//                           receives FlagW, PCS, NextPC, RegW, MemW, IRWrite,
//                           AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc,
//                           RegSrc, ALUControl, MulStart, Undef.
//   slave  (controller)   : the mirror image of master.
interface multicycle_ctrl_if #(
  parameter int ALUCTRL_W = 3
);
  logic [1:0]           Op;
  logic [5:0]           Funct;
  logic [3:0]           Rd;
  logic                 IsMul;
  logic                 MemReady;

  logic [1:0]           FlagW;
  logic                 PCS;
  logic                 NextPC;
  logic                 RegW;
  logic                 MemW;
  logic                 IRWrite;
  logic                 AdrSrc;
  logic [1:0]           ResultSrc;
  logic [1:0]           ALUSrcA;
  logic [1:0]           ALUSrcB;
  logic [1:0]           ImmSrc;
  logic [1:0]           RegSrc;
  logic [ALUCTRL_W-1:0] ALUControl;
  logic                 MulStart;
  logic                 Undef;

  modport master (
    output Op, Funct, Rd, IsMul, MemReady,
    input  FlagW, PCS, NextPC, RegW, MemW, IRWrite, AdrSrc, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl, MulStart, Undef
  );

  modport slave (
    input  Op, Funct, Rd, IsMul, MemReady,
    output FlagW, PCS, NextPC, RegW, MemW, IRWrite, AdrSrc, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl, MulStart, Undef
  );
endinterface

// File: rtl/multicycle_ctrl_alu_dec.sv
// ctrl_alu_dec
//   Combinational ALU/flag decoder.
//   aluOp      in   1          1 = decode Funct, 0 = plain ADD with no flag writes
//   funct      in   5          Funct[4:0] (command in [4:1], S bit in [0])
//   aluControl out  ALUCTRL_W  ALU operation, upper bits above bit 2 zero
//   flagW      out  2          [1]=NZ write enable, [0]=CV write enable
//   noWrite    out  1          compare/test: result is not written back
//   undefOp    out  1          command code is not in the supported set
module ctrl_alu_dec
  import multicycle_ctrl_pkg::*;
#(
  parameter int ALUCTRL_W = 3
) (
  input  logic                 aluOp,
  input  logic [4:0]           funct,
  output logic [ALUCTRL_W-1:0] aluControl,
  output logic [1:0]           flagW,
  output logic                 noWrite,
  output logic                 undefOp
);

  logic [2:0] opCode;
  logic       arith;

  // CV flags only make sense for add/subtract style ops; CMP and TST always
  // update their flags regardless of the S bit.
  always_comb begin
    opCode  = ALU_ADD;
    arith   = 1'b0;
    noWrite = 1'b0;
    undefOp = 1'b0;
    flagW   = 2'b00;
    if (aluOp) begin
      case (funct[4:1])
        CMD_ADD: begin opCode = ALU_ADD; arith = 1'b1; end
        CMD_SUB: begin opCode = ALU_SUB; arith = 1'b1; end
        CMD_AND: opCode = ALU_AND;
        CMD_ORR: opCode = ALU_ORR;
        CMD_EOR: opCode = ALU_EOR;
        CMD_MOV: opCode = ALU_MOV;
        CMD_CMP: begin opCode = ALU_SUB; arith = 1'b1; noWrite = 1'b1; end
        CMD_TST: begin opCode = ALU_AND; noWrite = 1'b1; end
        default: undefOp = 1'b1;
      endcase
      flagW = {funct[0], funct[0] & arith};
      if (funct[4:1] == CMD_CMP) begin
        flagW = 2'b11;
      end else if (funct[4:1] == CMD_TST) begin
        flagW = 2'b10;
      end
    end
  end

  assign aluControl = ALUCTRL_W'(opCode);

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
//   Main FSM, multiply latency counter, PC-select and instruction decode of
//   the multicycle core. Only the state and the multiply counter are
//   registered; every output is a combinational function of state and the
//   instruction fields.
//   clk    in  core clock
//   reset  in  synchronous, active-low reset
//   bus    slave modport of multicycle_ctrl_if (instruction fields and
//          MemReady in, datapath selects/strobes out)
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int MUL_LAT   = 4,
  parameter int ALUCTRL_W = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  multicycle_ctrl_if.slave      bus
);

  localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  state_t               state, nextState;
  logic [CNT_W-1:0]     mulCnt;
  logic                 mulFirst, mulDone;

  logic                 aluOp, branch, mulFlags;
  logic                 regWRaw, memWRaw, irWriteRaw, nextPcRaw;
  logic                 mulStartRaw, undefRaw;
  logic                 adrSrc;
  logic [1:0]           resultSrc, aluSrcA, aluSrcB;

  logic [ALUCTRL_W-1:0] decAluControl;
  logic [1:0]           decFlagW;
  logic                 decNoWrite, decUndef;

  ctrl_alu_dec #(.ALUCTRL_W(ALUCTRL_W)) u_alu_dec (
    .aluOp      (aluOp),
    .funct      (bus.Funct[4:0]),
    .aluControl (decAluControl),
    .flagW      (decFlagW),
    .noWrite    (decNoWrite),
    .undefOp    (decUndef)
  );

  // The counter only counts down, so it equals MUL_LAT-1 solely on the entry
  // cycle of MULEXEC; this also covers MUL_LAT=1 where entry and exit coincide.
  assign mulFirst = (mulCnt == CNT_W'(MUL_LAT - 1));
  assign mulDone  = (mulCnt == '0);

  // State register and multiply latency counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= S_FETCH;
      mulCnt <= '0;
    end else begin
      state <= nextState;
      if (state == S_DECODE && nextState == S_MULEXEC) begin
        mulCnt <= CNT_W'(MUL_LAT - 1);
      end else if (state == S_MULEXEC && !mulDone) begin
        mulCnt <= mulCnt - CNT_W'(1);
      end
    end
  end

  // Next-state and per-state datapath controls
  always_comb begin
    nextState   = state;
    aluOp       = 1'b0;
    branch      = 1'b0;
    mulFlags    = 1'b0;
    regWRaw     = 1'b0;
    memWRaw     = 1'b0;
    irWriteRaw  = 1'b0;
    nextPcRaw   = 1'b0;
    mulStartRaw = 1'b0;
    undefRaw    = 1'b0;
    adrSrc      = ADR_PC;
    resultSrc   = RES_ALUOUT;
    aluSrcA     = SRCA_RD1;
    aluSrcB     = SRCB_RD2;
    unique case (state)
      S_FETCH: begin
        aluSrcA    = SRCA_PC;
        aluSrcB    = SRCB_FOUR;
        resultSrc  = RES_ALURESULT;
        irWriteRaw = bus.MemReady;
        nextPcRaw  = bus.MemReady;
        if (bus.MemReady) nextState = S_DECODE;
      end
      S_DECODE: begin
        aluSrcA   = SRCA_PC;
        aluSrcB   = SRCB_FOUR;
        resultSrc = RES_ALURESULT;
        case (bus.Op)
          OP_MEM:    nextState = S_MEMADR;
          OP_BRANCH: nextState = S_BRANCH;
          OP_DP: begin
            if (bus.IsMul)         nextState = S_MULEXEC;
            else if (bus.Funct[5]) nextState = S_EXECI;
            else                   nextState = S_EXECR;
          end
          default: begin
            undefRaw  = 1'b1;
            nextState = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        aluSrcB   = SRCB_IMM;
        nextState = bus.Funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        adrSrc = ADR_ALU;
        if (bus.MemReady) nextState = S_MEMWB;
      end
      S_MEMWB: begin
        resultSrc = RES_READDATA;
        regWRaw   = 1'b1;
        nextState = S_FETCH;
      end
      S_MEMWR: begin
        adrSrc  = ADR_ALU;
        memWRaw = 1'b1;
        if (bus.MemReady) nextState = S_FETCH;
      end
      S_EXECR: begin
        aluOp     = 1'b1;
        undefRaw  = decUndef;
        nextState = S_ALUWB;
      end
      S_EXECI: begin
        aluOp     = 1'b1;
        aluSrcB   = SRCB_IMM;
        undefRaw  = decUndef;
        nextState = S_ALUWB;
      end
      S_ALUWB: begin
        aluOp     = 1'b1;
        regWRaw   = !decNoWrite;
        nextState = S_FETCH;
      end
      S_BRANCH: begin
        aluSrcB   = SRCB_IMM;
        resultSrc = RES_ALURESULT;
        branch    = 1'b1;
        nextState = S_FETCH;
      end
      S_MULEXEC: begin
        mulStartRaw = mulFirst;
        if (mulDone) nextState = S_MULWB;
      end
      S_MULWB: begin
        resultSrc = RES_MUL;
        regWRaw   = 1'b1;
        mulFlags  = 1'b1;
        nextState = S_FETCH;
      end
      default: nextState = S_FETCH;
    endcase
  end

  // All write strobes are held off while reset is low, so an instruction
  // interrupted by reset never commits anything.
  assign bus.RegW       = reset & regWRaw;
  assign bus.MemW       = reset & memWRaw;
  assign bus.IRWrite    = reset & irWriteRaw;
  assign bus.NextPC     = reset & nextPcRaw;
  assign bus.MulStart   = reset & mulStartRaw;
  assign bus.Undef      = reset & undefRaw;
  assign bus.PCS        = reset & (((bus.Rd == 4'hF) & regWRaw) | branch);
  assign bus.FlagW      = !reset   ? 2'b00 :
                          mulFlags ? {bus.Funct[0], 1'b0} : decFlagW;

  assign bus.AdrSrc     = adrSrc;
  assign bus.ResultSrc  = resultSrc;
  assign bus.ALUSrcA    = aluSrcA;
  assign bus.ALUSrcB    = aluSrcB;
  assign bus.ImmSrc     = bus.Op;
  assign bus.RegSrc     = regSrcOf(bus.Op);
  assign bus.ALUControl = decAluControl;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl
//   Scoreboard bench for multicycle_ctrl. Each instruction is expanded by a
//   behavioural model into the list of cycles it should take, with the
//   expected controls for each cycle; the stimulus process drives the cycles
//   and queues the expectations, monitor processes compare on the falling edge.
//   dut4 uses MUL_LAT=4 with a 4-bit ALUControl, dut1 uses MUL_LAT=1.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic [1:0] flagw;
    logic       pcs;
    logic       nextpc;
    logic       regw;
    logic       memw;
    logic       irwrite;
    logic       adrsrc;
    logic [1:0] ressrc;
    logic [1:0] srca;
    logic [1:0] srcb;
    logic [1:0] immsrc;
    logic [1:0] regsrc;
    logic [3:0] aluctl;
    logic       mulstart;
    logic       undef;
  } outs_t;

  typedef struct packed {
    outs_t v;
    logic  mr;
  } step_t;

  typedef struct {
    outs_t v;
    bit    strobesOnly;
  } exp_t;

  logic clk = 1'b0;
  logic rst4 = 1'b0;
  logic rst1 = 1'b0;
  always #5 clk = ~clk;

  multicycle_ctrl_if #(.ALUCTRL_W(4)) bus4 ();
  multicycle_ctrl_if #(.ALUCTRL_W(3)) bus1 ();

  multicycle_ctrl #(.MUL_LAT(4), .ALUCTRL_W(4)) dut4 (
    .clk   (clk),
    .reset (rst4),
    .bus   (bus4.slave)
  );

  multicycle_ctrl #(.MUL_LAT(1), .ALUCTRL_W(3)) dut1 (
    .clk   (clk),
    .reset (rst1),
    .bus   (bus1.slave)
  );

  outs_t act4, act1;
  assign act4 = {bus4.FlagW, bus4.PCS, bus4.NextPC, bus4.RegW, bus4.MemW,
                 bus4.IRWrite, bus4.AdrSrc, bus4.ResultSrc, bus4.ALUSrcA,
                 bus4.ALUSrcB, bus4.ImmSrc, bus4.RegSrc, bus4.ALUControl,
                 bus4.MulStart, bus4.Undef};
  assign act1 = {bus1.FlagW, bus1.PCS, bus1.NextPC, bus1.RegW, bus1.MemW,
                 bus1.IRWrite, bus1.AdrSrc, bus1.ResultSrc, bus1.ALUSrcA,
                 bus1.ALUSrcB, bus1.ImmSrc, bus1.RegSrc, {1'b0, bus1.ALUControl},
                 bus1.MulStart, bus1.Undef};

  exp_t q4[$];
  exp_t q1[$];
  int   nCompared   = 0;
  int   nMismatched = 0;

  // ALU reference tables: command code -> mnemonic -> operation code
  string mnemOf[bit [3:0]];
  int    codeOf[string];

  function automatic outs_t strobeMask();
    outs_t m;
    m          = '0;
    m.pcs      = 1'b1;
    m.nextpc   = 1'b1;
    m.regw     = 1'b1;
    m.memw     = 1'b1;
    m.irwrite  = 1'b1;
    m.mulstart = 1'b1;
    m.undef    = 1'b1;
    return m;
  endfunction

  function automatic logic coin();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic checkOutput(input string name, input outs_t act, input exp_t e);
    logic [23:0] m, a, w;
    m = e.strobesOnly ? strobeMask() : 24'hFFFFFF;
    a = act & m;
    w = e.v & m;
    nCompared++;
    if (a !== w) begin
      nMismatched++;
      $display("[TB] FAIL %s t=%0t got=%h want=%h mask=%h", name, $time, a, w, m);
    end
  endtask

  // Monitors: one expectation is queued per driven cycle
  initial forever begin
    @(negedge clk);
    if (q4.size() > 0) checkOutput("dut4_outputs", act4, q4.pop_front());
  end

  initial forever begin
    @(negedge clk);
    if (q1.size() > 0) checkOutput("dut1_outputs", act1, q1.pop_front());
  end

  task automatic drive(input int sel, input logic rstN, input logic [1:0] op,
                       input logic [5:0] funct, input logic [3:0] rd,
                       input logic ismul, input logic mr, input outs_t v,
                       input bit so);
    exp_t e;
    e.v = v;
    e.strobesOnly = so;
    if (sel == 0) begin
      rst4 = rstN; bus4.Op = op; bus4.Funct = funct; bus4.Rd = rd;
      bus4.IsMul = ismul; bus4.MemReady = mr;
      q4.push_back(e);
    end else begin
      rst1 = rstN; bus1.Op = op; bus1.Funct = funct; bus1.Rd = rd;
      bus1.IsMul = ismul; bus1.MemReady = mr;
      q1.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic resetCycles(input int sel, input int n);
    for (int i = 0; i < n; i++) drive(sel, 1'b0, 2'b00, 6'd0, 4'd0, 1'b0, coin(), '0, 1'b1);
  endtask

  // Expands one instruction into its expected cycles and drives them.
  // fwait/mwait: cycles of MemReady=0 before the fetch / memory access completes.
  // abortAt: cycle index replaced by a reset cycle (out of range = no abort).
  task automatic applyStimulus(input int sel, input logic [1:0] op, input logic [5:0] funct,
                               input logic [3:0] rd, input logic ismul, input int fwait,
                               input int mwait, input int abortAt);
    step_t      steps[$];
    outs_t      b, v;
    string      mn;
    int         code, mulLat;
    bit         nowr, arith;
    logic [1:0] fl;
    mulLat   = (sel == 0) ? 4 : 1;
    b        = '0;
    b.immsrc = op;
    b.regsrc = {op == 2'b01, op == 2'b10};
    // instruction fetch, stalled until memory responds
    v = b; v.srca = 2'b01; v.srcb = 2'b10; v.ressrc = 2'b10;
    for (int i = 0; i < fwait; i++) steps.push_back({v, 1'b0});
    v.irwrite = 1'b1; v.nextpc = 1'b1;
    steps.push_back({v, 1'b1});
    // decode
    v.irwrite = 1'b0; v.nextpc = 1'b0; v.undef = (op == 2'b11);
    steps.push_back({v, coin()});
    if (op == 2'b10) begin
      v = b; v.srcb = 2'b01; v.ressrc = 2'b10; v.pcs = 1'b1;
      steps.push_back({v, coin()});
    end else if (op == 2'b01) begin
      v = b; v.srcb = 2'b01;
      steps.push_back({v, coin()});
      if (funct[0]) begin
        v = b; v.adrsrc = 1'b1;
        for (int i = 0; i < mwait; i++) steps.push_back({v, 1'b0});
        steps.push_back({v, 1'b1});
        v = b; v.ressrc = 2'b01; v.regw = 1'b1; v.pcs = (rd == 4'hF);
        steps.push_back({v, coin()});
      end else begin
        v = b; v.adrsrc = 1'b1; v.memw = 1'b1;
        for (int i = 0; i < mwait; i++) steps.push_back({v, 1'b0});
        steps.push_back({v, 1'b1});
      end
    end else if (op == 2'b00 && ismul) begin
      for (int k = 0; k < mulLat; k++) begin
        v = b; v.mulstart = (k == 0);
        steps.push_back({v, coin()});
      end
      v = b; v.ressrc = 2'b11; v.regw = 1'b1; v.flagw = {funct[0], 1'b0};
      v.pcs = (rd == 4'hF);
      steps.push_back({v, coin()});
    end else if (op == 2'b00) begin
      mn    = mnemOf.exists(funct[4:1]) ? mnemOf[funct[4:1]] : "UND";
      code  = (mn == "UND") ? 0 : codeOf[mn];
      nowr  = (mn == "CMP") || (mn == "TST");
      arith = (mn == "ADD") || (mn == "SUB") || (mn == "CMP");
      fl    = {funct[0], funct[0] & arith};
      if (mn == "CMP") fl = 2'b11;
      if (mn == "TST") fl = 2'b10;
      v = b; v.srcb = funct[5] ? 2'b01 : 2'b00; v.aluctl = 4'(code); v.flagw = fl;
      v.undef = (mn == "UND");
      steps.push_back({v, coin()});
      v = b; v.aluctl = 4'(code); v.flagw = fl; v.regw = !nowr;
      v.pcs = !nowr && (rd == 4'hF);
      steps.push_back({v, coin()});
    end
    for (int i = 0; i < steps.size(); i++) begin
      if (i == abortAt) begin
        drive(sel, 1'b0, op, funct, rd, ismul, steps[i].mr, '0, 1'b1);
        return;
      end
      drive(sel, 1'b1, op, funct, rd, ismul, steps[i].mr, steps[i].v, 1'b0);
    end
  endtask

  initial begin
    logic [3:0] legal [8];
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic       ismul;
    int         r, abortAt;

    mnemOf[4'b0100] = "ADD"; mnemOf[4'b0010] = "SUB"; mnemOf[4'b0000] = "AND";
    mnemOf[4'b1100] = "ORR"; mnemOf[4'b0001] = "EOR"; mnemOf[4'b1101] = "MOV";
    mnemOf[4'b1010] = "CMP"; mnemOf[4'b1000] = "TST";
    codeOf["ADD"] = 0; codeOf["SUB"] = 1; codeOf["AND"] = 2; codeOf["ORR"] = 3;
    codeOf["EOR"] = 4; codeOf["MOV"] = 5; codeOf["CMP"] = 1; codeOf["TST"] = 2;
    legal = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b0001, 4'b1101, 4'b1010, 4'b1000};

    bus4.Op = 2'b00; bus4.Funct = 6'd0; bus4.Rd = 4'd0; bus4.IsMul = 1'b0; bus4.MemReady = 1'b0;
    bus1.Op = 2'b00; bus1.Funct = 6'd0; bus1.Rd = 4'd0; bus1.IsMul = 1'b0; bus1.MemReady = 1'b0;
    @(posedge clk);
    #1;

    resetCycles(0, 2);
    applyStimulus(0, 2'b00, 6'b001000, 4'd1,  1'b0, 0, 0, 1000);  // ADD R1,R2,R3
    applyStimulus(0, 2'b01, 6'b011001, 4'hF,  1'b0, 1, 3, 1000);  // LDR PC with 3 waits
    applyStimulus(0, 2'b00, 6'b010101, 4'd0,  1'b0, 0, 0, 1000);  // CMP
    applyStimulus(0, 2'b00, 6'b000001, 4'hF,  1'b1, 0, 0, 1000);  // MULS to PC
    applyStimulus(0, 2'b11, 6'b101010, 4'd3,  1'b0, 0, 0, 1000);  // undefined class
    applyStimulus(0, 2'b01, 6'b011000, 4'd2,  1'b0, 0, 2, 3);     // STR reset in MEMWR
    applyStimulus(0, 2'b00, 6'b100110, 4'd4,  1'b0, 0, 0, 1000);  // undefined ALU cmd, imm
    applyStimulus(0, 2'b10, 6'b100000, 4'd0,  1'b0, 2, 0, 1000);  // branch

    for (int n = 0; n < 160; n++) begin
      r  = $urandom_range(0, 9);
      op = (r < 5) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      funct = 6'($urandom);
      if (op == 2'b00 && $urandom_range(0, 3) != 0) funct[4:1] = legal[$urandom_range(0, 7)];
      ismul   = (op == 2'b00) && ($urandom_range(0, 3) == 0);
      rd      = coin() ? 4'hF : 4'($urandom);
      abortAt = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 10) : 1000;
      applyStimulus(0, op, funct, rd, ismul, $urandom_range(0, 2), $urandom_range(0, 3), abortAt);
    end

    resetCycles(1, 2);
    applyStimulus(1, 2'b00, 6'b000000, 4'd2, 1'b1, 0, 0, 1000);
    applyStimulus(1, 2'b00, 6'b000001, 4'hF, 1'b1, 1, 0, 1000);
    applyStimulus(1, 2'b00, 6'b101001, 4'd5, 1'b0, 0, 0, 1000);

    for (int k = 0; k < 10 && (q4.size() > 0 || q1.size() > 0); k++) @(negedge clk);
    nCompared++;
    if (q4.size() > 0 || q1.size() > 0) begin
      nMismatched++;
      $display("[TB] FAIL scoreboard_drain left=%0d want=0", q4.size() + q1.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired at t=%0t want=finish", $time);
    $fatal(1, "[TB] watchdog");
  end

endmodule
